// File: rtl/prism_cfg_pkg.sv
// Shared register map, bit positions and FSM encodings for the PRISM configuration loader.
package prism_cfg_pkg;

    localparam logic [5:0] OFF_DATA_LO = 6'h00;
    localparam logic [5:0] OFF_DATA_HI = 6'h04;
    localparam logic [5:0] OFF_CTRL    = 6'h08;
    localparam logic [5:0] OFF_STATUS  = 6'h0C;
    localparam logic [5:0] OFF_RD_LO   = 6'h10;
    localparam logic [5:0] OFF_RD_HI   = 6'h14;
    localparam logic [5:0] REG_SPAN    = 6'h18;

    localparam int unsigned CTRL_MODE    = 0;
    localparam int unsigned CTRL_IDX_LSB = 4;
    localparam int unsigned CTRL_LOCK    = 8;
    localparam int unsigned CTRL_CLEAR   = 9;

    localparam int unsigned STAT_BUSY     = 0;
    localparam int unsigned STAT_VALID    = 1;
    localparam int unsigned STAT_ERR      = 2;
    localparam int unsigned STAT_IRQ      = 3;
    localparam int unsigned STAT_LOCKED   = 4;
    localparam int unsigned STAT_MASK_LSB = 16;

    localparam int unsigned IDX_W = 4;

    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE  = 2'd0;
    localparam fsm_state_t ST_LOAD  = 2'd1;
    localparam fsm_state_t ST_CLEAR = 2'd2;

    // Entry indices are 4 bits wide but DEPTH may be smaller; guard every array access.
    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx, input int unsigned depth);
        return 32'(idx) < depth;
    endfunction

endpackage

// File: rtl/prism_cfg_store.sv
// WIDTH x DEPTH flop store: shift-in, indexed write, indexed zero, flattened output and read mux.
module prism_cfg_store
    import prism_cfg_pkg::*;
#(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     shift_en,
    input  logic                     idx_wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     zero_en,
    input  logic [IDX_W-1:0]         zero_idx,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [WIDTH-1:0]         rd_data,
    output logic [WIDTH*DEPTH-1:0]   cfg_bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (shift_en) begin
            mem[0] <= wr_data;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end else if (idx_wr_en) begin
            if (idx_in_range(wr_idx, DEPTH)) begin
                mem[wr_idx[AW-1:0]] <= wr_data;
            end
        end else if (zero_en) begin
            if (idx_in_range(zero_idx, DEPTH)) begin
                mem[zero_idx[AW-1:0]] <= '0;
            end
        end
    end

    always_comb begin
        cfg_bus = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cfg_bus[i*WIDTH +: WIDTH] = mem[i];
        end
    end

    always_comb begin
        rd_data = '0;
        if (idx_in_range(rd_idx, DEPTH)) begin
            rd_data = mem[rd_idx[AW-1:0]];
        end
    end

endmodule

// File: rtl/prism_cfg_loader.sv
// PRISM configuration loader: bus decode, staging register, commit/clear FSM, valid mask and flags.
module prism_cfg_loader
    import prism_cfg_pkg::*;
#(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 8,
    parameter logic [5:0]  BASE  = 6'h08
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [5:0]               address,
    input  logic [31:0]              data_in,
    input  logic [1:0]               data_write_n,
    input  logic [1:0]               data_read_n,
    output logic [31:0]              data_out,
    output logic                     data_ready,
    output logic [WIDTH*DEPTH-1:0]   cfg_bus,
    output logic                     cfg_valid,
    output logic                     busy,
    output logic                     irq
);

    localparam int unsigned      AW   = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    fsm_state_t        state;
    logic [WIDTH-1:0]  stage;
    logic [DEPTH-1:0]  mask;
    logic              mode;
    logic [IDX_W-1:0]  idx;
    logic              lock;
    logic              err;
    logic              irq_pend;
    logic              cfg_valid_q;
    logic [IDX_W-1:0]  clr_cnt;

    logic              hit;
    logic [5:0]        off;
    logic              wr_any, wr_word, rd_any;
    logic              wr_lo, wr_hi, wr_ctrl, wr_stat;
    logic              commit_req, clear_req, commit_go, clear_go, err_set;
    logic [WIDTH-1:0]  rd_data;
    logic [31:0]       status_word, ctrl_word;

    assign hit     = ({1'b0, address} >= {1'b0, BASE}) &&
                     ({1'b0, address} <  ({1'b0, BASE} + {1'b0, REG_SPAN}));
    assign off     = address - BASE;
    assign wr_any  = data_write_n != 2'b11;
    assign wr_word = data_write_n == 2'b10;
    assign rd_any  = data_read_n  != 2'b11;

    assign wr_lo   = hit && wr_word && (off == OFF_DATA_LO);
    assign wr_hi   = hit && wr_word && (off == OFF_DATA_HI);
    assign wr_ctrl = hit && wr_any  && (off == OFF_CTRL);
    assign wr_stat = hit && wr_any  && (off == OFF_STATUS);

    assign busy       = state != ST_IDLE;
    assign commit_req = wr_hi;
    assign clear_req  = wr_ctrl && data_in[CTRL_CLEAR];
    assign commit_go  = commit_req && !busy && !lock;
    assign clear_go   = clear_req  && !busy && !lock;
    assign err_set    = (commit_req || clear_req) && (busy || lock);

    assign cfg_valid  = &mask;
    assign irq        = irq_pend;
    assign data_ready = 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            stage       <= '0;
            mask        <= '0;
            mode        <= 1'b0;
            idx         <= '0;
            lock        <= 1'b0;
            err         <= 1'b0;
            irq_pend    <= 1'b0;
            cfg_valid_q <= 1'b0;
            clr_cnt     <= '0;
        end else begin
            if (wr_lo) stage[31:0]       <= data_in;
            if (wr_hi) stage[WIDTH-1:32] <= data_in[WIDTH-33:0];
            cfg_valid_q <= cfg_valid;

            if (wr_ctrl) begin
                mode <= data_in[CTRL_MODE];
                idx  <= data_in[CTRL_IDX_LSB +: IDX_W];
                if (data_in[CTRL_LOCK]) lock <= 1'b1;
            end

            // A CTRL write coinciding with the LOAD cycle owns idx; a clear entry overrides it with 0.
            case (state)
                ST_IDLE: begin
                    if (commit_go) begin
                        state <= ST_LOAD;
                    end else if (clear_go) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                        mask    <= '0;
                        idx     <= '0;
                    end
                end
                ST_LOAD: begin
                    state <= ST_IDLE;
                    if (!mode) begin
                        mask <= {mask[DEPTH-2:0], 1'b1};
                    end else begin
                        if (idx_in_range(idx, DEPTH)) mask[idx[AW-1:0]] <= 1'b1;
                        if (!wr_ctrl) idx <= (idx == LAST) ? '0 : idx + 1'b1;
                    end
                end
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (wr_stat && data_in[STAT_ERR]) err <= 1'b0;
            if (err_set) err <= 1'b1;

            if (wr_stat && data_in[STAT_IRQ]) irq_pend <= 1'b0;
            if (cfg_valid && !cfg_valid_q) irq_pend <= 1'b1;
        end
    end

    prism_cfg_store #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_en  ((state == ST_LOAD) && !mode),
        .idx_wr_en ((state == ST_LOAD) && mode),
        .wr_idx    (idx),
        .wr_data   (stage),
        .zero_en   (state == ST_CLEAR),
        .zero_idx  (clr_cnt),
        .rd_idx    (idx),
        .rd_data   (rd_data),
        .cfg_bus   (cfg_bus)
    );

    always_comb begin
        status_word                           = '0;
        status_word[STAT_BUSY]                = busy;
        status_word[STAT_VALID]               = cfg_valid;
        status_word[STAT_ERR]                 = err;
        status_word[STAT_IRQ]                 = irq_pend;
        status_word[STAT_LOCKED]              = lock;
        status_word[STAT_MASK_LSB +: DEPTH]   = mask;

        ctrl_word                             = '0;
        ctrl_word[CTRL_MODE]                  = mode;
        ctrl_word[CTRL_IDX_LSB +: IDX_W]      = idx;
        ctrl_word[CTRL_LOCK]                  = lock;
    end

    always_comb begin
        data_out = '0;
        if (hit && rd_any) begin
            case (off)
                OFF_CTRL:   data_out = ctrl_word;
                OFF_STATUS: data_out = status_word;
                OFF_RD_LO:  data_out = rd_data[31:0];
                OFF_RD_HI:  data_out = 32'(rd_data[WIDTH-1:32]);
                default:    data_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_prism_cfg_loader.sv
// Randomised bench for prism_cfg_loader against a transaction-level reference model.
module tb_prism_cfg_loader;

    localparam int W = 48;
    localparam int D = 8;

    localparam logic [5:0] A_LO   = 6'h08;
    localparam logic [5:0] A_HI   = 6'h0C;
    localparam logic [5:0] A_CTRL = 6'h10;
    localparam logic [5:0] A_STAT = 6'h14;
    localparam logic [5:0] A_RDLO = 6'h18;
    localparam logic [5:0] A_RDHI = 6'h1C;

    logic             clk;
    logic             rst_n;
    logic [5:0]       address;
    logic [31:0]      data_in;
    logic [1:0]       data_write_n;
    logic [1:0]       data_read_n;
    logic [31:0]      data_out;
    logic             data_ready;
    logic [W*D-1:0]   cfg_bus;
    logic             cfg_valid;
    logic             busy;
    logic             irq;

    prism_cfg_loader #(
        .WIDTH (W),
        .DEPTH (D),
        .BASE  (6'h08)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .address      (address),
        .data_in      (data_in),
        .data_write_n (data_write_n),
        .data_read_n  (data_read_n),
        .data_out     (data_out),
        .data_ready   (data_ready),
        .cfg_bus      (cfg_bus),
        .cfg_valid    (cfg_valid),
        .busy         (busy),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: register-level view of the loader
    logic [W-1:0] m_ent [D];
    logic [D-1:0] m_mask;
    logic [W-1:0] m_stage;
    logic         m_mode, m_lock, m_err, m_irq;
    int           m_idx;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < D; i++) m_ent[i] = '0;
        m_mask = '0; m_stage = '0; m_mode = 0; m_lock = 0; m_err = 0; m_irq = 0; m_idx = 0;
    endtask

    task automatic m_commit();
        logic was_full;
        was_full = &m_mask;
        if (m_lock) begin
            m_err = 1;
        end else if (!m_mode) begin
            for (int i = D - 1; i > 0; i--) m_ent[i] = m_ent[i-1];
            m_ent[0] = m_stage;
            m_mask   = {m_mask[D-2:0], 1'b1};
        end else begin
            m_ent[m_idx]  = m_stage;
            m_mask[m_idx] = 1'b1;
            m_idx         = (m_idx + 1) % D;
        end
        if (!was_full && (&m_mask)) m_irq = 1;
    endtask

    task automatic m_ctrl(input logic [31:0] d);
        logic old_lock;
        old_lock = m_lock;
        m_mode = d[0];
        m_idx  = int'(d[7:4]);
        if (d[8]) m_lock = 1;
        if (d[9]) begin
            if (old_lock) begin
                m_err = 1;
            end else begin
                for (int i = 0; i < D; i++) m_ent[i] = '0;
                m_mask = '0;
                m_idx  = 0;
            end
        end
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
        @(negedge clk);
        address = a; data_in = d; data_write_n = wn;
        @(posedge clk);
        #1;
        data_write_n = 2'b11;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; data_read_n = 2'b00;
        #1;
        d = data_out;
        data_read_n = 2'b11;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_commit(input logic [31:0] lo, input logic [31:0] hi);
        bus_write(A_LO, lo, 2'b10);
        bus_write(A_HI, hi, 2'b10);
        idle_cycles(3);
        m_stage = {hi[15:0], lo};
        m_commit();
    endtask

    task automatic do_ctrl(input logic [31:0] d);
        bus_write(A_CTRL, d, 2'b00);
        idle_cycles(D + 3);
        m_ctrl(d);
    endtask

    task automatic check_all();
        logic [31:0] r;
        logic [31:0] exp;
        for (int i = 0; i < D; i++) check($sformatf("entry%0d", i), 64'(cfg_bus[i*W +: W]), 64'(m_ent[i]));
        check("cfg_valid", cfg_valid, &m_mask);
        check("irq", irq, m_irq);
        check("busy_idle", busy, 0);
        exp = {16'(m_mask), 11'b0, m_lock, m_irq, m_err, (&m_mask), 1'b0};
        bus_read(A_STAT, r);
        check("status", r, exp);
        exp = {23'b0, m_lock, 4'(m_idx), 3'b0, m_mode};
        bus_read(A_CTRL, r);
        check("ctrl", r, exp);
        bus_read(A_RDLO, r);
        check("rd_lo", r, m_ent[m_idx][31:0]);
        bus_read(A_RDHI, r);
        check("rd_hi", r, {16'h0, m_ent[m_idx][W-1:32]});
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        int          cnt;
        int          op;
        logic [31:0] d;

        rst_n = 0; address = '0; data_in = '0; data_write_n = 2'b11; data_read_n = 2'b11;
        m_reset();
        idle_cycles(3);
        rst_n = 1;
        idle_cycles(1);

        check("data_ready", data_ready, 1);
        check_all();

        // Shift mode: eight commits, valid/irq timing on the last one
        for (int k = 0; k < D - 1; k++) do_commit(32'(k + 1), 32'h0);
        bus_write(A_LO, 32'(D), 2'b10);
        bus_write(A_HI, 32'h0, 2'b10);
        check("load_busy", busy, 1);
        check("valid_pre", cfg_valid, 0);
        idle_cycles(1);
        check("valid_n2", cfg_valid, 1);
        check("irq_n2", irq, 0);
        idle_cycles(1);
        check("irq_n3", irq, 1);
        m_stage = {16'h0, 32'(D)};
        m_commit();
        check("shift_e0", 64'(cfg_bus[0 +: W]), 64'd8);
        check("shift_e7", 64'(cfg_bus[7*W +: W]), 64'd1);
        check_all();

        // Indexed mode with idx wrap
        do_ctrl(32'h61);
        do_commit(32'h1234_5678, 32'hBEEF);
        do_commit(32'h0BAD_F00D, 32'hCAFE);
        check("idx_e6", 64'(cfg_bus[6*W +: W]), 64'h0000_BEEF_1234_5678);
        check("idx_e7", 64'(cfg_bus[7*W +: W]), 64'h0000_CAFE_0BAD_F00D);
        bus_read(A_CTRL, r);
        check("idx_wrap", r, 32'h1);
        do_ctrl(32'h61);
        bus_read(A_RDHI, r);
        check("rd_hi_e6", r, 32'h0000_BEEF);
        check_all();

        // Commit while busy is dropped and flagged
        bus_write(A_LO, 32'hA5A5_0001, 2'b10);
        bus_write(A_HI, 32'h1111, 2'b10);
        bus_write(A_HI, 32'h2222, 2'b10);
        idle_cycles(3);
        m_stage = {16'h1111, 32'hA5A5_0001};
        m_commit();
        m_stage = {16'h2222, 32'hA5A5_0001};
        m_err = 1;
        check_all();
        bus_write(A_STAT, 32'h4, 2'b10);
        m_err = 0;
        check_all();

        // Clear sequence length
        bus_write(A_CTRL, 32'h200, 2'b10);
        cnt = 0;
        while (busy && cnt < 50) begin
            cnt++;
            idle_cycles(1);
        end
        check("clear_cycles", cnt, D);
        idle_cycles(1);
        m_ctrl(32'h200);
        check_all();

        // Randomised mix
        repeat (60) begin
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                do_commit($urandom, $urandom);
            end else if (op <= 6) begin
                d = {22'b0, 2'b00, 4'($urandom_range(0, D - 1)), 3'b0, 1'($urandom)};
                do_ctrl(d);
            end else if (op == 7) begin
                if ($urandom_range(0, 2) == 0) do_ctrl(32'h200 | 32'(m_mode));
                else do_commit($urandom, $urandom);
            end else if (op == 8) begin
                d = $urandom & 32'h0000_000C;
                bus_write(A_STAT, d, 2'b10);
                if (d[2]) m_err = 0;
                if (d[3]) m_irq = 0;
                idle_cycles(1);
            end else begin
                bus_write(A_HI, $urandom, 2'($urandom_range(0, 1)));
                check("narrow_no_busy", busy, 0);
                idle_cycles(2);
            end
            check_all();
        end

        // Lock: commits and clears rejected
        do_ctrl(32'h100 | 32'(m_mode) | (32'(m_idx) << 4));
        do_commit(32'hDEAD_BEEF, 32'h7777);
        check_all();
        do_ctrl(32'h200 | 32'(m_mode) | (32'(m_idx) << 4));
        check_all();
        check("lock_err", m_err, 1'b1);

        @(negedge clk); rst_n = 0;
        idle_cycles(1);
        rst_n = 1;
        m_reset();
        check_all();

        // Reset in the middle of a clear
        do_commit(32'h0000_0042, 32'h0042);
        do_commit(32'h0000_0043, 32'h0043);
        check_all();
        bus_write(A_CTRL, 32'h200, 2'b10);
        idle_cycles(3);
        check("clear_busy_mid", busy, 1);
        @(negedge clk); rst_n = 0;
        idle_cycles(1);
        m_reset();
        check("rst_busy", busy, 0);
        check("rst_valid", cfg_valid, 0);
        check("rst_irq", irq, 0);
        check("rst_ready", data_ready, 1);
        for (int i = 0; i < D; i++) check($sformatf("rst_entry%0d", i), 64'(cfg_bus[i*W +: W]), 64'(m_ent[i]));
        rst_n = 1;
        idle_cycles(1);
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
